// File: rtl/drop_sequencer_pkg.sv
// rtl/drop_sequencer_pkg.sv - shared state encodings, colour/LFSR constants and spawn helpers
package drop_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_FALL  = 3'd2;
    localparam logic [2:0] ST_CATCH = 3'd3;
    localparam logic [2:0] ST_MISS  = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    localparam logic [1:0]  COLOR_NONE = 2'b00;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Folds a 9-bit random value into [x_min, x_max] with a single compare-subtract.
    function automatic logic [9:0] spawn_x(input logic [8:0] r, input logic [9:0] x_min,
                                           input logic [9:0] x_max);
        logic [9:0] w_r;
        logic [9:0] w_span_m1;
        w_r       = {1'b0, r};
        w_span_m1 = x_max - x_min;
        if (w_r <= w_span_m1)
            return x_min + w_r;
        return x_min + w_r - w_span_m1 - 10'd1;
    endfunction

    function automatic logic [1:0] spawn_color(input logic [1:0] c);
        return (c == COLOR_NONE) ? 2'b01 : c;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16
    import drop_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= SEED;
        else
            r_q <= {r_q[14:0], ^(r_q & LFSR_TAPS)};
    end

    assign q = r_q;

endmodule

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - game-flow FSM: spawns, drops and scores falling blocks for the stack
module drop_sequencer
    import drop_sequencer_pkg::*;
#(
    parameter int          X_MIN      = 100,
    parameter int          X_MAX      = 490,
    parameter int          Y_START    = 0,
    parameter int          Y_FLOOR    = 420,
    parameter int          STEP       = 2,
    parameter int          LIVES      = 3,
    parameter int          MAX_BLOCKS = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic        collision,
    input  logic [9:0]  stack_height,
    output logic [9:0]  fall_x,
    output logic [9:0]  fall_y,
    output logic [1:0]  fall_color,
    output logic        fall_active,
    output logic        stack_clr,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        game_over
);

    logic [15:0] w_lfsr;
    logic [10:0] w_y_next;
    logic        w_unused_lfsr;

    logic [2:0]  r_state;
    logic [9:0]  r_fall_x;
    logic [9:0]  r_fall_y;
    logic [1:0]  r_fall_color;
    logic        r_fall_active;
    logic        r_stack_clr;
    logic [15:0] r_score;
    logic [1:0]  r_lives;
    logic        r_game_over;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:11];
    // One spare bit so a wrap past 1023 still reads as reaching the floor.
    assign w_y_next = {1'b0, r_fall_y} + 11'(STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_fall_x      <= 10'(X_MIN);
            r_fall_y      <= 10'(Y_START);
            r_fall_color  <= COLOR_NONE;
            r_fall_active <= 1'b0;
            r_stack_clr   <= 1'b0;
            r_score       <= 16'd0;
            r_lives       <= 2'(LIVES);
            r_game_over   <= 1'b0;
        end else begin
            r_stack_clr <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    r_fall_active <= 1'b0;
                    if (start) begin
                        r_stack_clr <= 1'b1;
                        r_score     <= 16'd0;
                        r_lives     <= 2'(LIVES);
                        r_game_over <= 1'b0;
                        r_state     <= ST_SPAWN;
                    end
                end
                ST_SPAWN: begin
                    r_fall_x      <= spawn_x(w_lfsr[8:0], 10'(X_MIN), 10'(X_MAX));
                    r_fall_color  <= spawn_color(w_lfsr[10:9]);
                    r_fall_y      <= 10'(Y_START);
                    r_fall_active <= 1'b1;
                    r_state       <= ST_FALL;
                end
                ST_FALL: begin
                    if (collision) begin
                        r_state <= ST_CATCH;
                    end else if (tick) begin
                        r_fall_y <= w_y_next[9:0];
                        if (w_y_next >= 11'(Y_FLOOR))
                            r_state <= ST_MISS;
                    end
                end
                ST_CATCH: begin
                    r_fall_active <= 1'b0;
                    if (r_score != 16'hFFFF)
                        r_score <= r_score + 16'd1;
                    if (stack_height >= 10'(MAX_BLOCKS)) begin
                        r_game_over <= 1'b1;
                        r_state     <= ST_OVER;
                    end else begin
                        r_state <= ST_SPAWN;
                    end
                end
                ST_MISS: begin
                    r_fall_active <= 1'b0;
                    if (r_lives <= 2'd1) begin
                        r_lives     <= 2'd0;
                        r_game_over <= 1'b1;
                        r_state     <= ST_OVER;
                    end else begin
                        r_lives <= r_lives - 2'd1;
                        r_state <= ST_SPAWN;
                    end
                end
                default: begin
                    r_fall_active <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign fall_x      = r_fall_x;
    assign fall_y      = r_fall_y;
    assign fall_color  = r_fall_color;
    assign fall_active = r_fall_active;
    assign stack_clr   = r_stack_clr;
    assign score       = r_score;
    assign lives       = r_lives;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - scoreboard bench for drop_sequencer spawn, fall, catch, miss and reset
module tb_drop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tick;
    logic        collision;
    logic [9:0]  stack_height;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    logic [1:0]  fall_color;
    logic        fall_active;
    logic        stack_clr;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        game_over;

    always #5 clk = ~clk;

    drop_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tick         (tick),
        .collision    (collision),
        .stack_height (stack_height),
        .fall_x       (fall_x),
        .fall_y       (fall_y),
        .fall_color   (fall_color),
        .fall_active  (fall_active),
        .stack_clr    (stack_clr),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic [1:0]  lives;
        logic [15:0] score;
    } exp_t;

    exp_t spawn_q[$];
    exp_t over_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_spawn(input int l, input int s);
        exp_t t;
        t.lives = 2'(l);
        t.score = 16'(s);
        spawn_q.push_back(t);
    endtask

    task automatic push_over(input int l, input int s);
        exp_t t;
        t.lives = 2'(l);
        t.score = 16'(s);
        over_q.push_back(t);
    endtask

    // Reference LFSR; m_prev is the value the design saw during the last clock.
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    function automatic int exp_x(input logic [15:0] v);
        int r;
        r = int'(v[8:0]);
        return (r <= 390) ? 100 + r : r - 291;
    endfunction

    function automatic int exp_color(input logic [15:0] v);
        return (v[10:9] == 2'b00) ? 1 : int'(v[10:9]);
    endfunction

    logic prev_active = 1'b0;
    logic prev_over = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_active = 1'b0;
            prev_over   = 1'b0;
        end else begin
            if (fall_active && !prev_active) begin
                if (spawn_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spawn_unexpected: got spawn x=%0d expected none", fall_x);
                end else begin
                    mon_e = spawn_q.pop_front();
                    chk("spawn_x", 32'(fall_x), 32'(exp_x(m_prev)));
                    chk("spawn_color", 32'(fall_color), 32'(exp_color(m_prev)));
                    chk("spawn_y", 32'(fall_y), 32'd0);
                    chk("spawn_lives", 32'(lives), 32'(mon_e.lives));
                    chk("spawn_score", 32'(score), 32'(mon_e.score));
                    chk("spawn_game_over", 32'(game_over), 32'd0);
                end
            end
            if (game_over && !prev_over) begin
                if (over_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL over_unexpected: got game_over=1 expected 0");
                end else begin
                    mon_e = over_q.pop_front();
                    chk("over_lives", 32'(lives), 32'(mon_e.lives));
                    chk("over_score", 32'(score), 32'(mon_e.score));
                    chk("over_active", 32'(fall_active), 32'd0);
                end
            end
            prev_active = fall_active;
            prev_over   = game_over;
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"}, 32'(fall_x), 32'd100);
        chk({tag, "_y"}, 32'(fall_y), 32'd0);
        chk({tag, "_color"}, 32'(fall_color), 32'd0);
        chk({tag, "_active"}, 32'(fall_active), 32'd0);
        chk({tag, "_clr"}, 32'(stack_clr), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_pulse_on", 32'(stack_clr), 32'd1);
        chk("clr_active_low", 32'(fall_active), 32'd0);
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_score", 32'(score), 32'd0);
        chk("start_over_low", 32'(game_over), 32'd0);
        @(negedge clk);
        chk("clr_pulse_off", 32'(stack_clr), 32'd0);
        chk("start_active", 32'(fall_active), 32'd1);
    endtask

    task automatic ticks(input int n, input bit check_y, input int y0);
        for (int i = 1; i <= n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            if (check_y)
                chk("fall_y_step", 32'(fall_y), 32'(y0 + 2 * i));
        end
        tick = 1'b0;
    endtask

    task automatic do_miss(input int lives_after);
        ticks(210, 1'b0, 0);
        chk("miss_y_floor", 32'(fall_y), 32'd420);
        @(negedge clk);
        chk("miss_active_low", 32'(fall_active), 32'd0);
        chk("miss_lives", 32'(lives), 32'(lives_after));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tick = 1'b0;
        collision = 1'b0;
        stack_height = 10'd0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        collision = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        tick = 1'b0;
        chk("idle_y", 32'(fall_y), 32'd0);
        chk("idle_score", 32'(score), 32'd0);
        chk("idle_active", 32'(fall_active), 32'd0);

        push_spawn(3, 0);
        do_start();

        push_spawn(2, 0);
        ticks(210, 1'b1, 0);
        @(negedge clk);
        chk("miss1_active", 32'(fall_active), 32'd0);
        chk("miss1_lives", 32'(lives), 32'd2);
        chk("miss1_y", 32'(fall_y), 32'd420);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_clr", 32'(stack_clr), 32'd0);
        chk("start_ignored_y", 32'(fall_y), 32'd0);

        ticks(50, 1'b0, 0);
        chk("catch_y_pre", 32'(fall_y), 32'd100);
        stack_height = 10'd5;
        push_spawn(2, 1);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        chk("catch_y_hold", 32'(fall_y), 32'd100);
        chk("catch_active_hold", 32'(fall_active), 32'd1);
        @(negedge clk);
        chk("catch_active_low", 32'(fall_active), 32'd0);
        chk("catch_score", 32'(score), 32'd1);
        chk("catch_over_low", 32'(game_over), 32'd0);
        @(negedge clk);

        ticks(3, 1'b0, 0);
        push_spawn(2, 2);
        tick = 1'b1;
        collision = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        collision = 1'b0;
        chk("prio_y", 32'(fall_y), 32'd6);
        @(negedge clk);
        chk("prio_score", 32'(score), 32'd2);
        chk("prio_lives", 32'(lives), 32'd2);
        @(negedge clk);

        push_spawn(1, 2);
        do_miss(1);
        push_over(0, 2);
        do_miss(0);
        chk("over_after_miss", 32'(game_over), 32'd1);
        ticks(4, 1'b0, 0);
        chk("over_y_frozen", 32'(fall_y), 32'd420);

        push_spawn(3, 0);
        do_start();
        push_spawn(2, 0);
        do_miss(2);
        push_spawn(1, 0);
        do_miss(1);
        push_over(0, 0);
        do_miss(0);
        chk("three_miss_over", 32'(game_over), 32'd1);
        push_spawn(3, 0);
        do_start();

        ticks(5, 1'b0, 0);
        stack_height = 10'd16;
        push_over(3, 1);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        @(negedge clk);
        chk("full_over", 32'(game_over), 32'd1);
        chk("full_score", 32'(score), 32'd1);
        stack_height = 10'd0;
        push_spawn(3, 0);
        do_start();
        ticks(4, 1'b0, 0);
        chk("pre_abort_y", 32'(fall_y), 32'd8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_state("async");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("spawn_q_drained", 32'(spawn_q.size()), 32'd0);
        chk("over_q_drained", 32'(over_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
